iter_shift_unit: RTL and testbench
==================================

# iter_shift_unit

Parametrised, iterative shift/rotate engine generalising the 6502 ASL/LSR/ROL/ROR datapath to any operand width, multi-bit shift amounts and extra modes (arithmetic right, rotate without carry). It sits beside the ALU as a multicycle functional unit. It shifts one bit per clock under a start/done handshake and returns result, carry-out and N/Z flags. The microsequencer launches it for shift-class opcodes and for wide (16-bit) address arithmetic.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (>= 2)
- AMT_W, $clog2(WIDTH+1), width of the shift-amount port (derived localparam, not overridden)

Ports:
- ph2  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- op  input  3  operation code (see Operation)
- amount  input  AMT_W  number of single-bit steps
- din  input  WIDTH  operand
- cin  input  1  carry in
- ready  output  1  unit can accept start this cycle
- busy  output  1  shift in progress
- done  output  1  one-cycle pulse, result valid
- dout  output  WIDTH  result; held until next accepted start
- cout  output  1  carry out; held with dout
- zero  output  1  dout == 0
- neg  output  1  dout[WIDTH-1]

## Operation
- Ops: 0 ASL (0 in at LSB, MSB to carry); 1 LSR (0 in at MSB, LSB to carry); 2 ROL (WIDTH+1-bit rotate through carry); 3 ROR (WIDTH+1-bit rotate through carry); 4 ASR (MSB replicated, LSB to carry); 5 ROLN (rotate, carry = bit moved out, carry not fed back); 6 RORN (same, right); 7 NOP (dout=din, cout=cin).
- Each step applies the op once to {reg, c}; amount steps total. Any amount value is legal, including >= WIDTH (iterative semantics, no clamping).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: ready=1. On start, load reg=din, c=cin, cnt=amount, latch op. Go to DONE if amount==0 or op==NOP, else go to SHIFT.
  - SHIFT: busy=1, ready=0. Each edge performs one step and decrements cnt. On the edge where cnt goes 1->0, go to DONE.
  - DONE: done=1 for exactly one cycle, ready=1. A start in DONE is accepted (back-to-back), with the same transitions as IDLE. Otherwise go to IDLE.
- dout/cout/zero/neg reflect reg/c. They are only guaranteed valid while done=1 and are held afterward until the next accepted start.
- start while busy: ignored, with no effect on the current operation.
- op/amount/din/cin changes after acceptance: no effect.

## Timing
- Reset values: state=IDLE, ready=1, busy=0, done=0, dout=0, cout=0, zero=1, neg=0.
- Let edge k be the edge that accepts start. done is high in the cycle following edge k+n, where n=amount (n=0 or NOP -> following edge k).
- Throughput: one operation per n+1 cycles. Back-to-back issue on the done cycle is allowed.
- Reset asserted in any state aborts the operation at the next edge: all outputs take their reset values and no done pulse is produced. Reset dominates a simultaneous start.
- zero and neg are combinational from the registered dout, so they add no extra latency.

## Structure
- Package shift_pkg: shift_op_t enum (ASL, LSR, ROL, ROR, ASR, ROLN, RORN, NOP), state_t enum (IDLE, SHIFT, DONE).
- Sub-module shift_step (parametrised on WIDTH): purely combinational single-step function, {reg, c, op} -> {reg', c'}. It is instantiated once inside iter_shift_unit and is reusable by the ALU for single-cycle shifts.
- Top level contains the FSM, counter, operand/carry registers and flag logic.

## Test plan
- WIDTH=8, ASL din=0xB7 cin=0 amount=1 -> done one cycle after acceptance, dout=0x6E, cout=1, zero=0, neg=0.
- WIDTH=8: LSR 0xDD amt 1 -> 0x6E/cout 1; ROR 0xDC cin 0 amt 1 -> 0x6E/cout 0; ROL 0x37 cin 0 amt 1 -> 0x6E/cout 0.
- WIDTH=8, ROL din=0x81 cin=1 amount=9 -> done 9 cycles after acceptance, dout=0x81, cout=1 (full 9-bit rotation). ASR 0x80 amt 3 -> 0xF0, cout=0, neg=1.
- WIDTH=16, RORN din=0x0001 amount=4 -> dout=0x1000, cout=0. LSR 0x8000 amt 16 -> dout=0x0000, zero=1, cout=1.
- Handshake: amount=0 ASL 0x55 -> done after one cycle, dout=0x55, cout=cin. A start pulsed during SHIFT is ignored. A start on the done cycle is accepted, and its result appears amount cycles later.
- Reset asserted mid-SHIFT (amount=5, after 2 steps) -> next cycle ready=1, busy=0, done=0, dout=0, zero=1. No done pulse follows.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the iterative shift/rotate engine and its single-step datapath.
package shift_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ASL  = 3'd0,
    LSR  = 3'd1,
    ROL  = 3'd2,
    ROR  = 3'd3,
    ASR  = 3'd4,
    ROLN = 3'd5,
    RORN = 3'd6,
    NOP  = 3'd7
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // NOP never iterates, so it completes straight from the accept edge.
  function automatic logic op_is_nop(input logic [OP_W-1:0] op);
    return shift_op_t'(op) == NOP;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One application of a shift/rotate op to {reg, carry}; purely combinational.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  shift_op_t        op,
  input  logic [WIDTH-1:0] din,
  input  logic             cin,
  output logic [WIDTH-1:0] dout,
  output logic             cout
);

  always_comb begin
    dout = din;
    cout = cin;
    case (op)
      ASL: begin
        dout = {din[WIDTH-2:0], 1'b0};
        cout = din[WIDTH-1];
      end
      LSR: begin
        dout = {1'b0, din[WIDTH-1:1]};
        cout = din[0];
      end
      ROL: begin
        dout = {din[WIDTH-2:0], cin};
        cout = din[WIDTH-1];
      end
      ROR: begin
        dout = {cin, din[WIDTH-1:1]};
        cout = din[0];
      end
      ASR: begin
        dout = {din[WIDTH-1], din[WIDTH-1:1]};
        cout = din[0];
      end
      // Rotates without carry still report the bit that wrapped around.
      ROLN: begin
        dout = {din[WIDTH-2:0], din[WIDTH-1]};
        cout = din[WIDTH-1];
      end
      RORN: begin
        dout = {din[0], din[WIDTH-1:1]};
        cout = din[0];
      end
      default: begin
        dout = din;
        cout = cin;
      end
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multicycle shift/rotate unit: one single-bit step per ph2 edge, amount steps per op.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             ph2,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output state_t           dbg_state
);

  // Handshake: an operation is accepted on a rising edge where start && ready.
  // ready is high in IDLE and DONE (back-to-back issue on the done cycle);
  // done pulses for one cycle and dout/cout stay put until the next accept.

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic             carry;
  logic [AMT_W-1:0] cnt;
  shift_op_t        op_q;
  logic             accept;
  logic [WIDTH-1:0] step_reg;
  logic             step_c;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op   (op_q),
    .din  (sreg),
    .cin  (carry),
    .dout (step_reg),
    .cout (step_c)
  );

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE, DONE: begin
        ready = 1'b1;
        done  = (state == DONE);
        if (start) begin
          accept   = 1'b1;
          state_nx = (amount == '0 || op_is_nop(op)) ? DONE : SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == AMT_W'(1)) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ph2) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      op_q  <= NOP;
    end else begin
      state <= state_nx;
      if (accept) begin
        sreg  <= din;
        carry <= cin;
        cnt   <= amount;
        op_q  <= shift_op_t'(op);
      end else if (state == SHIFT) begin
        sreg  <= step_reg;
        carry <= step_c;
        cnt   <= cnt - AMT_W'(1);
      end
    end
  end

  assign dout      = sreg;
  assign cout      = carry;
  assign zero      = (sreg == '0);
  assign neg       = sreg[WIDTH-1];
  assign dbg_state = state;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_iter_shift_unit;
  import shift_pkg::*;

  logic ph2 = 1'b0;
  logic reset;

  logic        start8, cin8;
  logic [2:0]  op8;
  logic [3:0]  amt8;
  logic [7:0]  din8;
  logic        ready8, busy8, done8, cout8, zero8, neg8;
  logic [7:0]  dout8;
  state_t      st8;

  logic        start16, cin16;
  logic [2:0]  op16;
  logic [4:0]  amt16;
  logic [15:0] din16;
  logic        ready16, busy16, done16, cout16, zero16, neg16;
  logic [15:0] dout16;
  state_t      st16;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] exp_q[$];
  logic [16:0] last_exp[2];

  iter_shift_unit #(.WIDTH(8)) u_dut8 (
    .ph2(ph2), .reset(reset), .start(start8), .op(op8), .amount(amt8),
    .din(din8), .cin(cin8), .ready(ready8), .busy(busy8), .done(done8),
    .dout(dout8), .cout(cout8), .zero(zero8), .neg(neg8), .dbg_state(st8)
  );

  iter_shift_unit #(.WIDTH(16)) u_dut16 (
    .ph2(ph2), .reset(reset), .start(start16), .op(op16), .amount(amt16),
    .din(din16), .cin(cin16), .ready(ready16), .busy(busy16), .done(done16),
    .dout(dout16), .cout(cout16), .zero(zero16), .neg(neg16), .dbg_state(st16)
  );

  // clock / reset
  always #5 ph2 = ~ph2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: closed-form shifts and rotations of the whole operand
  function automatic logic [16:0] ref_shift(input int w, input int op, input int n,
                                            input logic [15:0] d, input logic c);
    longint unsigned mw, m1, dv, x, y, y1;
    longint s;
    int k;
    logic cr;
    mw = (64'd1 << w) - 64'd1;
    m1 = (64'd1 << (w + 1)) - 64'd1;
    dv = 64'(d) & mw;
    y  = dv;
    cr = c;
    if (op != 7 && n != 0) begin
      case (op)
        0: begin
          x  = dv << n;
          y  = x & mw;
          cr = ((x >> w) & 64'd1) != 0;
        end
        1: begin
          y  = dv >> n;
          cr = ((dv >> (n - 1)) & 64'd1) != 0;
        end
        2, 3: begin
          x  = (64'(c) << w) | dv;
          k  = (op == 2) ? (n % (w + 1)) : ((w + 1 - n % (w + 1)) % (w + 1));
          y1 = ((x << k) | (x >> (w + 1 - k))) & m1;
          y  = y1 & mw;
          cr = ((y1 >> w) & 64'd1) != 0;
        end
        4: begin
          s  = d[w-1] ? longint'(dv) - longint'(64'd1 << w) : longint'(dv);
          y  = 64'(s >>> n) & mw;
          cr = ((s >>> (n - 1)) & 64'sd1) != 0;
        end
        default: begin
          k  = (op == 5) ? (n % w) : ((w - n % w) % w);
          y  = ((dv << k) | (dv >> (w - k))) & mw;
          cr = (op == 5) ? ((y & 64'd1) != 0) : (((y >> (w - 1)) & 64'd1) != 0);
        end
      endcase
    end
    return {cr, 16'(y)};
  endfunction

  function automatic logic [15:0] rd_dout(input bit wide);
    return wide ? dout16 : {8'h00, dout8};
  endfunction
  function automatic logic [4:0] rd_flags(input bit wide);
    // {ready, busy, done, zero, neg}
    return wide ? {ready16, busy16, done16, zero16, neg16} : {ready8, busy8, done8, zero8, neg8};
  endfunction
  function automatic logic rd_cout(input bit wide);
    return wide ? cout16 : cout8;
  endfunction

  // driver tasks
  task automatic drive(input bit wide, input logic st, input int op, input int amt,
                       input logic [15:0] d, input logic c);
    if (wide) begin
      start16 = st; op16 = 3'(op); amt16 = 5'(amt); din16 = d; cin16 = c;
    end else begin
      start8 = st; op8 = 3'(op); amt8 = 4'(amt); din8 = d[7:0]; cin8 = c;
    end
  endtask

  task automatic scramble(input bit wide, input logic st);
    drive(wide, st, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
          16'($urandom), 1'($urandom));
  endtask

  // Called just after a falling edge; returns just after the falling edge where done is seen.
  task automatic do_op(input bit wide, input int op, input int n, input logic [15:0] d,
                       input logic c, input bit poke);
    int w = wide ? 16 : 8;
    int lat;
    int exp_lat;
    bit got;
    logic [16:0] e;
    logic [4:0] f;
    check("ready_pre", 32'(rd_flags(wide)[4]), 32'd1);
    exp_q.push_back(ref_shift(w, op, n, d, c));
    exp_lat = (n == 0 || op == 7) ? 1 : n + 1;
    drive(wide, 1'b1, op, n, d, c);
    @(posedge ph2);
    #1 scramble(wide, 1'b0);
    got = 1'b0;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge ph2);
      if (poke && lat == 2) scramble(wide, 1'b0);
      f = rd_flags(wide);
      if (f[2]) begin
        got = 1'b1;
        break;
      end
      if (lat == 1) begin
        check("busy_shift", 32'(f[4:3]), 32'b01);
        if (poke) scramble(wide, 1'b1);
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      scramble(wide, 1'b0);
    end else begin
      check("latency", 32'(lat), 32'(exp_lat));
    end
    check("dout", 32'(rd_dout(wide)), 32'(e[15:0]));
    check("cout", 32'(rd_cout(wide)), 32'(e[16]));
    check("zero", 32'(rd_flags(wide)[1]), 32'(e[15:0] == 16'h0));
    check("neg", 32'(rd_flags(wide)[0]), 32'(e[w-1]));
    last_exp[wide] = e;
  endtask

  task automatic idle(input bit wide, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge ph2);
      check("idle_flags", 32'(rd_flags(wide)[4:2]), 32'b100);
      check("idle_hold", 32'({rd_cout(wide), rd_dout(wide)}), 32'(last_exp[wide]));
    end
  endtask

  initial begin
    int w_sel;
    int n;
    reset = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 16'h0, 1'b0);
    last_exp[0] = '0;
    last_exp[1] = '0;
    repeat (3) @(posedge ph2);
    @(negedge ph2);
    check("rst_flags8", 32'({rd_flags(0), rd_cout(0), rd_dout(0)}), {16'h0, 5'b10010, 1'b0, 16'h0} >> 0);
    check("rst_flags16", 32'({rd_flags(1), rd_cout(1)}), 32'({5'b10010, 1'b0}));
    check("rst_dout16", 32'(rd_dout(1)), 32'h0);
    check("rst_state", 32'(st8), 32'(IDLE));
    reset = 1'b0;
    @(negedge ph2);

    // directed cases
    do_op(0, 0, 1, 16'h00B7, 1'b0, 0);
    idle(0, 1);
    do_op(0, 1, 1, 16'h00DD, 1'b0, 0);
    do_op(0, 3, 1, 16'h00DC, 1'b0, 0);
    do_op(0, 2, 1, 16'h0037, 1'b0, 0);
    do_op(0, 2, 9, 16'h0081, 1'b1, 0);
    do_op(0, 4, 3, 16'h0080, 1'b0, 0);
    idle(0, 2);
    do_op(1, 6, 4, 16'h0001, 1'b1, 0);
    do_op(1, 1, 16, 16'h8000, 1'b0, 0);
    idle(1, 1);
    do_op(0, 0, 0, 16'h0055, 1'b1, 0);
    do_op(0, 7, 9, 16'h00C3, 1'b0, 0);
    do_op(0, 5, 6, 16'h00A1, 1'b0, 1);
    do_op(0, 0, 3, 16'h0011, 1'b1, 0);
    idle(0, 1);

    // reset in the middle of a shift: no done pulse afterwards
    drive(0, 1'b1, 4, 5, 16'h00A5, 1'b1);
    @(posedge ph2);
    #1 drive(0, 1'b0, 0, 0, 16'h0, 1'b0);
    repeat (3) @(negedge ph2);
    reset = 1'b1;
    @(negedge ph2);
    check("rst_mid_flags", 32'({rd_flags(0), rd_cout(0)}), 32'({5'b10010, 1'b0}));
    check("rst_mid_dout", 32'(rd_dout(0)), 32'h0);
    reset = 1'b0;
    last_exp[0] = '0;
    last_exp[1] = '0;
    idle(0, 8);

    // randomized operations, with idle gaps of zero for back-to-back issue
    for (int i = 0; i < 120; i++) begin
      w_sel = int'($urandom_range(0, 1));
      n = (w_sel != 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 15));
      do_op(w_sel[0], int'($urandom_range(0, 7)), n, 16'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0));
      idle(w_sel[0], int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
